// File: rtl/sc_background_lane_datapath.sv
// ---------------------------------------------------------------------------
// sc_background_lane_datapath
// Datapath for one scrolling background lane. Executes the active-low
// commands (clear / load / shift select / upcount / loadLast) issued by the
// background state machine and returns the active-low scroll-timer flag T0.
//
// Optional build macro: LANE_SPEEDUP_EN
//   defined   -> every executed rotate counts toward a speed-up; each
//                SPEEDUP_SHIFTS rotates shorten the scroll period by one,
//                saturating at MIN_PERIOD. clear restores the full period.
//   undefined -> the scroll period is fixed at PERIOD.
// ---------------------------------------------------------------------------
module sc_background_lane_datapath #(
    parameter int              WIDTH          = 8,
    parameter logic [WIDTH-1:0] INIT_PATTERN  = 8'b1100_0110,
    parameter int              PERIOD         = 25,
    parameter int              MIN_PERIOD     = 5,
    parameter int              SPEEDUP_SHIFTS = 4
) (
    input  logic             SC_BGLANE_CLOCK_50,
    input  logic             SC_BGLANE_RESET_InHigh,
    input  logic             SC_BGLANE_clear_InLow,
    input  logic             SC_BGLANE_load_InLow,
    input  logic [1:0]       SC_BGLANE_shiftselection_In,
    input  logic             SC_BGLANE_upcount_InLow,
    input  logic             SC_BGLANE_loadLastRegister_InLow,
    input  logic [WIDTH-1:0] SC_BGLANE_data_In,
    output logic [WIDTH-1:0] SC_BGLANE_lane_Out,
    output logic [WIDTH-1:0] SC_BGLANE_last_Out,
    output logic             SC_BGLANE_T0_OutLow
);

    // Timer holds 0..PERIOD-1; the period value itself needs one more code.
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int EFF_W = $clog2(PERIOD + 1);

    logic [WIDTH-1:0] laneReg;
    logic [WIDTH-1:0] laneNext;
    logic [WIDTH-1:0] lastReg;
    logic [WIDTH-1:0] rotLeft;
    logic [WIDTH-1:0] rotRight;
    logic [CNT_W-1:0] countReg;
    logic [CNT_W-1:0] countAdv;
    logic [CNT_W-1:0] countNext;
    logic [EFF_W-1:0] effPeriod;
    logic [EFF_W-1:0] effLast;
    logic             rotateExec;

    // Wrapping rotations: every bit moves one column, none lost or inserted.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rotLeft[gi]  = laneReg[(gi + WIDTH - 1) % WIDTH];
            assign rotRight[gi] = laneReg[(gi + 1) % WIDTH];
        end
    endgenerate

    // Lane command priority: clear, then load, then shift selection.
    always_comb begin
        laneNext   = laneReg;
        rotateExec = 1'b0;
        if (!SC_BGLANE_clear_InLow) begin
            laneNext = INIT_PATTERN;
        end else if (!SC_BGLANE_load_InLow) begin
            laneNext = SC_BGLANE_data_In;
        end else if (SC_BGLANE_shiftselection_In == 2'b10) begin
            laneNext   = rotLeft;
            rotateExec = 1'b1;
        end else if (SC_BGLANE_shiftselection_In == 2'b01) begin
            laneNext   = rotRight;
            rotateExec = 1'b1;
        end
    end

    assign effLast = effPeriod - 1'b1;

    // Scroll timer advance: wrap at the last step of the current period.
    always_comb begin
        countAdv = countReg;
        if (!SC_BGLANE_upcount_InLow) begin
            countAdv = (EFF_W'(countReg) == effLast) ? '0 : countReg + 1'b1;
        end
    end

`ifdef LANE_SPEEDUP_EN
    localparam int SH_W = $clog2(SPEEDUP_SHIFTS + 1);

    logic [SH_W-1:0]  shiftCntReg;
    logic [SH_W-1:0]  shiftCntNext;
    logic [EFF_W-1:0] effPeriodReg;
    logic [EFF_W-1:0] effNext;
    logic [EFF_W-1:0] effNextLast;

    // Count executed rotates; every SPEEDUP_SHIFTS of them shortens the period.
    always_comb begin
        shiftCntNext = shiftCntReg;
        effNext      = effPeriodReg;
        if (rotateExec) begin
            if (shiftCntReg == SH_W'(SPEEDUP_SHIFTS - 1)) begin
                shiftCntNext = '0;
                if (effPeriodReg > EFF_W'(MIN_PERIOD)) begin
                    effNext = effPeriodReg - 1'b1;
                end
            end else begin
                shiftCntNext = shiftCntReg + 1'b1;
            end
        end
    end

    // A shrinking period must never leave the timer beyond its new last step.
    assign effNextLast = effNext - 1'b1;
    assign countNext   = (EFF_W'(countAdv) > effNextLast) ? '0 : countAdv;
    assign effPeriod   = effPeriodReg;

    // Speed-up state; clear returns the lane to its full period.
    always_ff @(posedge SC_BGLANE_CLOCK_50) begin
        if (SC_BGLANE_RESET_InHigh || !SC_BGLANE_clear_InLow) begin
            shiftCntReg  <= '0;
            effPeriodReg <= EFF_W'(PERIOD);
        end else begin
            shiftCntReg  <= shiftCntNext;
            effPeriodReg <= effNext;
        end
    end
`else
    assign effPeriod = EFF_W'(PERIOD);
    assign countNext = countAdv;
`endif

    // Lane, snapshot and timer registers; reset discards any command.
    always_ff @(posedge SC_BGLANE_CLOCK_50) begin
        if (SC_BGLANE_RESET_InHigh) begin
            laneReg  <= INIT_PATTERN;
            lastReg  <= '0;
            countReg <= '0;
        end else begin
            laneReg <= laneNext;
            // Snapshot takes the pre-update lane, whatever command runs.
            if (!SC_BGLANE_loadLastRegister_InLow) begin
                lastReg <= laneReg;
            end
            countReg <= (!SC_BGLANE_clear_InLow) ? '0 : countNext;
        end
    end

    assign SC_BGLANE_lane_Out  = laneReg;
    assign SC_BGLANE_last_Out  = lastReg;
    assign SC_BGLANE_T0_OutLow = (EFF_W'(countReg) == effLast) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_sc_background_lane_datapath.sv
// ---------------------------------------------------------------------------
// tb_sc_background_lane_datapath
// Directed vectors with hand-computed expectations for the lane datapath.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_background_lane_datapath;

    logic       clk = 1'b0;
    logic       srst;
    logic       clearN;
    logic       loadN;
    logic [1:0] shiftSel;
    logic       upcountN;
    logic       loadLastN;
    logic [7:0] dataIn;
    logic [7:0] laneOut;
    logic [7:0] lastOut;
    logic       t0N;

    int errCount   = 0;
    int checkCount = 0;

    always #10 clk = ~clk;

    sc_background_lane_datapath dut (
        .SC_BGLANE_CLOCK_50               (clk),
        .SC_BGLANE_RESET_InHigh           (srst),
        .SC_BGLANE_clear_InLow            (clearN),
        .SC_BGLANE_load_InLow             (loadN),
        .SC_BGLANE_shiftselection_In      (shiftSel),
        .SC_BGLANE_upcount_InLow          (upcountN),
        .SC_BGLANE_loadLastRegister_InLow (loadLastN),
        .SC_BGLANE_data_In                (dataIn),
        .SC_BGLANE_lane_Out               (laneOut),
        .SC_BGLANE_last_Out               (lastOut),
        .SC_BGLANE_T0_OutLow              (t0N)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clearN    = 1'b1;
        loadN     = 1'b1;
        shiftSel  = 2'b00;
        upcountN  = 1'b1;
        loadLastN = 1'b1;
        dataIn    = 8'h00;
    endtask

    // Upcount n times from count 0: T0 must stay high until the n-th step.
    task automatic runTimer(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            upcountN = 1'b0;
            cycle();
            if (i >= n - 1)
                checkVal($sformatf("%s_step%0d", tag, i), {31'd0, t0N}, (i == n) ? 32'd0 : 32'd1);
        end
        upcountN = 1'b0;
        cycle();
        checkVal({tag, "_wrap"}, {31'd0, t0N}, 32'd1);
        upcountN = 1'b1;
    endtask

    initial begin
        idle();
        srst = 1'b1;
        cycle();
        cycle();
        srst = 1'b0;
        checkVal("reset_lane", {24'd0, laneOut}, 32'hC6);
        checkVal("reset_last", {24'd0, lastOut}, 32'h00);
        checkVal("reset_t0",   {31'd0, t0N},     32'd1);

        // Full scroll period from a zeroed timer.
        runTimer(25 - 1, "timer");
        cycle();
        checkVal("timer_hold", {31'd0, t0N}, 32'd1);

        // Rotations and hold codes.
        shiftSel = 2'b10; cycle();
        checkVal("rotl_C6", {24'd0, laneOut}, 32'h8D);
        shiftSel = 2'b00; loadN = 1'b0; dataIn = 8'h81; cycle();
        loadN = 1'b1;
        checkVal("load_81", {24'd0, laneOut}, 32'h81);
        shiftSel = 2'b01; cycle();
        checkVal("rotr_81", {24'd0, laneOut}, 32'hC0);
        shiftSel = 2'b00; cycle();
        checkVal("hold_00", {24'd0, laneOut}, 32'hC0);
        shiftSel = 2'b11; cycle();
        checkVal("hold_11", {24'd0, laneOut}, 32'hC0);
        shiftSel = 2'b00; loadN = 1'b0; dataIn = 8'h80; cycle();
        loadN = 1'b1; shiftSel = 2'b10; cycle();
        checkVal("rotl_wrap_80", {24'd0, laneOut}, 32'h01);
        shiftSel = 2'b01; cycle();
        checkVal("rotr_wrap_01", {24'd0, laneOut}, 32'h80);
        shiftSel = 2'b00;

        // Advance timer a little, then clear+load+shift+upcount on one edge.
        upcountN = 1'b0; cycle(); cycle(); cycle();
        clearN = 1'b0; loadN = 1'b0; shiftSel = 2'b10; dataIn = 8'hFF;
        cycle();
        idle();
        checkVal("clear_prio_lane", {24'd0, laneOut}, 32'hC6);
        runTimer(25 - 1, "clear_timer");

        // Snapshot takes the pre-edge lane while load updates it.
        loadN = 1'b0; dataIn = 8'h3C; cycle();
        loadLastN = 1'b0; dataIn = 8'h01; cycle();
        idle();
        checkVal("snap_last", {24'd0, lastOut}, 32'h3C);
        checkVal("snap_lane", {24'd0, laneOut}, 32'h01);
        clearN = 1'b0; loadLastN = 1'b0; cycle();
        idle();
        checkVal("snap_clear_last", {24'd0, lastOut}, 32'h01);
        checkVal("snap_clear_lane", {24'd0, laneOut}, 32'hC6);
        clearN = 1'b0; cycle();
        idle();
        checkVal("clear_keeps_last", {24'd0, lastOut}, 32'h01);

        // Reset mid-operation wins over simultaneous commands.
        upcountN = 1'b0; cycle(); cycle();
        srst = 1'b1; loadN = 1'b0; dataIn = 8'h55; loadLastN = 1'b0;
        cycle();
        srst = 1'b0;
        idle();
        checkVal("midrst_lane", {24'd0, laneOut}, 32'hC6);
        checkVal("midrst_last", {24'd0, lastOut}, 32'h00);
        checkVal("midrst_t0",   {31'd0, t0N},     32'd1);
        runTimer(25 - 1, "midrst_timer");

`ifdef LANE_SPEEDUP_EN
        // Four rotates shorten the period to 24.
        for (int i = 0; i < 4; i++) begin
            shiftSel = 2'b10; cycle();
        end
        shiftSel = 2'b00;
        runTimer(24 - 1, "speed_24");
        // Eighty rotates reach and hold the floor of 5.
        clearN = 1'b0; cycle(); clearN = 1'b1;
        for (int i = 0; i < 80; i++) begin
            shiftSel = 2'b01; cycle();
        end
        shiftSel = 2'b00;
        runTimer(5 - 1, "speed_floor");
        clearN = 1'b0; cycle(); clearN = 1'b1;
        runTimer(25 - 1, "speed_clear");
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
